// File: rtl/motor602_uart_cmd_rx_pkg.sv
// Shared constants for the motor602 UART command receiver: command bytes, FSM encodings, default clocking.
// Latency: n/a (constants only).
// Backpressure: n/a. Optional MOTOR602_UART_PARITY_EN adds the PARITY state encoding.
package motor602_uart_cmd_rx_pkg;

    // Default board clock and link rate
    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int BAUD_DEF   = 115_200;

    // Single-character host commands (case sensitive)
    localparam logic [7:0] CMD_START   = 8'h53;  // 'S'
    localparam logic [7:0] CMD_STOP    = 8'h58;  // 'X'
    localparam logic [7:0] CMD_INV     = 8'h52;  // 'R'
    localparam logic [7:0] CMD_SPD_INC = 8'h2B;  // '+'
    localparam logic [7:0] CMD_SPD_DEC = 8'h2D;  // '-'
    localparam logic [7:0] CMD_PWR_INC = 8'h50;  // 'P'
    localparam logic [7:0] CMD_PWR_DEC = 8'h70;  // 'p'

    // Receiver FSM encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BREAK  = 3'd4;
`ifdef MOTOR602_UART_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif

endpackage

// File: rtl/motor602_uart_rx_core.sv
// UART byte receiver (8N1, or 8E1 with MOTOR602_UART_PARITY_EN): 2-flop synchroniser, framing FSM, byte/status pulses.
// Latency: rxValidO/frameErrO/parityErrO rise the cycle after the stop-bit sample edge; byteLoadO is the same-cycle strobe.
// Backpressure: none; the line cannot be stalled, so every byte is presented exactly once.
module motor602_uart_rx_core
    import motor602_uart_cmd_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
)(
    input  logic       clkI,
    input  logic       rstI,
    input  logic       uRxI,
    output logic [7:0] rxByteO,
    output logic       rxValidO,
    output logic       frameErrO,
`ifdef MOTOR602_UART_PARITY_EN
    output logic       parityErrO,
`endif
    output logic [7:0] byteNextO,
    output logic       byteLoadO
);

    // Counter also times the post-reset idle qualification, which is two bit times long
    localparam int CNT_W = $clog2(2 * CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(2 * CLKS_PER_BIT - 1);

    logic             rxMeta;
    logic             rxS;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic             armed;
    logic             bitDone;
    logic             parityOk;

`ifdef MOTOR602_UART_PARITY_EN
    logic parityBit;
    assign parityOk = ~^{shiftReg, parityBit};
`else
    assign parityOk = 1'b1;
`endif

    assign bitDone   = (cnt == BIT_LAST);
    assign byteNextO = shiftReg;
    assign byteLoadO = (state == ST_STOP) && bitDone && rxS && parityOk;

    // Two-flop synchroniser; preset high so reset looks like an idle line
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= uRxI;
            rxS    <= rxMeta;
        end
    end

    // Framing FSM; after reset, start bits are only accepted once the line has idled high
    // for two bit times, so the tail of an interrupted frame cannot be mistaken for a new one
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            armed     <= 1'b0;
            rxByteO   <= '0;
            rxValidO  <= 1'b0;
            frameErrO <= 1'b0;
`ifdef MOTOR602_UART_PARITY_EN
            parityBit  <= 1'b0;
            parityErrO <= 1'b0;
`endif
        end else begin
            rxValidO  <= 1'b0;
            frameErrO <= 1'b0;
`ifdef MOTOR602_UART_PARITY_EN
            parityErrO <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (!armed) begin
                        if (!rxS) begin
                            cnt <= '0;
                        end else if (cnt == ARM_LAST) begin
                            armed <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else if (!rxS) begin
                        // IDLE is only entered with the line high, so low here is a falling edge
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= rxS ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bitDone) begin
                        cnt      <= '0;
                        shiftReg <= {rxS, shiftReg[7:1]};
                        bitIdx   <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
`ifdef MOTOR602_UART_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef MOTOR602_UART_PARITY_EN
                ST_PARITY: begin
                    if (bitDone) begin
                        cnt       <= '0;
                        parityBit <= rxS;
                        state     <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (bitDone) begin
                        cnt <= '0;
                        if (!rxS) begin
                            // Framing error wins over any parity result
                            frameErrO <= 1'b1;
                            state     <= ST_BREAK;
                        end else begin
                            state <= ST_IDLE;
                            if (parityOk) begin
                                rxByteO  <= shiftReg;
                                rxValidO <= 1'b1;
                            end
`ifdef MOTOR602_UART_PARITY_EN
                            else begin
                                parityErrO <= 1'b1;
                            end
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line has been continuously high for a full bit
                    if (!rxS) begin
                        cnt <= '0;
                    end else if (bitDone) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/motor602_uart_cmd_rx.sv
// Host command receiver: UART bytes decoded into motor push-button pulses and the rotation-invert level.
// Latency: command pulses and the invert toggle land in the same cycle as rxValidO (cycle after stop-bit sample).
// Backpressure: none; each decoded command is a single-cycle pulse. Optional MOTOR602_UART_PARITY_EN selects 8E1 + parityErrO.
module motor602_uart_cmd_rx
    import motor602_uart_cmd_rx_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEF,
    parameter int BAUD         = BAUD_DEF,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD  // must be >= 4
)(
    input  logic       clkI,
    input  logic       rstI,
    input  logic       uRxI,
    output logic [7:0] rxByteO,
    output logic       rxValidO,
    output logic       frameErrO,
`ifdef MOTOR602_UART_PARITY_EN
    output logic       parityErrO,
`endif
    output logic       m3startO,
    output logic       m3forceStopO,
    output logic       m3invRotateO,
    output logic       m3speedINCo,
    output logic       m3speedDECo,
    output logic       m3powerINCo,
    output logic       m3powerDECo
);

    logic [7:0] byteNext;
    logic       byteLoad;

    motor602_uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) uCore (
        .clkI       (clkI),
        .rstI       (rstI),
        .uRxI       (uRxI),
        .rxByteO    (rxByteO),
        .rxValidO   (rxValidO),
        .frameErrO  (frameErrO),
`ifdef MOTOR602_UART_PARITY_EN
        .parityErrO (parityErrO),
`endif
        .byteNextO  (byteNext),
        .byteLoadO  (byteLoad)
    );

    // Registered command decode off the core's load strobe, so pulses align with rxValidO
    always_ff @(posedge clkI or posedge rstI) begin
        if (rstI) begin
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3invRotateO <= 1'b0;
            m3speedINCo  <= 1'b0;
            m3speedDECo  <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;
        end else begin
            m3startO     <= 1'b0;
            m3forceStopO <= 1'b0;
            m3speedINCo  <= 1'b0;
            m3speedDECo  <= 1'b0;
            m3powerINCo  <= 1'b0;
            m3powerDECo  <= 1'b0;
            if (byteLoad) begin
                case (byteNext)
                    CMD_START:   m3startO     <= 1'b1;
                    CMD_STOP:    m3forceStopO <= 1'b1;
                    CMD_INV:     m3invRotateO <= ~m3invRotateO;
                    CMD_SPD_INC: m3speedINCo  <= 1'b1;
                    CMD_SPD_DEC: m3speedDECo  <= 1'b1;
                    CMD_PWR_INC: m3powerINCo  <= 1'b1;
                    CMD_PWR_DEC: m3powerDECo  <= 1'b1;
                    default:     ;  // unknown byte: rxValidO only
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor602_uart_cmd_rx.sv
// Directed bench for motor602_uart_cmd_rx at CLK_HZ=1MHz, BAUD=100k (10 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_motor602_uart_cmd_rx;

    localparam int CPB = 10;

    logic       clkI = 1'b0;
    logic       rstI = 1'b1;
    logic       uRxI = 1'b1;
    logic [7:0] rxByteO;
    logic       rxValidO, frameErrO;
    logic       m3startO, m3forceStopO, m3invRotateO;
    logic       m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo;
`ifdef MOTOR602_UART_PARITY_EN
    logic       parityErrO;
    logic       parFlip = 1'b0;
    int         cPerr = 0;
`endif

    int nCmp  = 0;
    int nFail = 0;

    // Pulse-cycle counters: 0 start,1 forceStop,2 spdInc,3 spdDec,4 pwrInc,5 pwrDec
    int cmdCnt [6];
    int cVld    = 0;
    int cFerr   = 0;
    int cCoin   = 0;  // cycles with m3startO and rxValidO together
    int cOrphan = 0;  // cycles with a command pulse but no rxValidO

    motor602_uart_cmd_rx #(
        .CLK_HZ (1_000_000),
        .BAUD   (100_000)
    ) dut (
        .clkI         (clkI),
        .rstI         (rstI),
        .uRxI         (uRxI),
        .rxByteO      (rxByteO),
        .rxValidO     (rxValidO),
        .frameErrO    (frameErrO),
`ifdef MOTOR602_UART_PARITY_EN
        .parityErrO   (parityErrO),
`endif
        .m3startO     (m3startO),
        .m3forceStopO (m3forceStopO),
        .m3invRotateO (m3invRotateO),
        .m3speedINCo  (m3speedINCo),
        .m3speedDECo  (m3speedDECo),
        .m3powerINCo  (m3powerINCo),
        .m3powerDECo  (m3powerDECo)
    );

    always #5 clkI = ~clkI;

    always @(negedge clkI) begin
        logic [5:0] cmds;
        cmds = {m3powerDECo, m3powerINCo, m3speedDECo, m3speedINCo, m3forceStopO, m3startO};
        for (int i = 0; i < 6; i++) if (cmds[i]) cmdCnt[i] = cmdCnt[i] + 1;
        if (rxValidO) cVld = cVld + 1;
        if (frameErrO) cFerr = cFerr + 1;
        if (m3startO && rxValidO) cCoin = cCoin + 1;
        if ((|cmds) && !rxValidO) cOrphan = cOrphan + 1;
`ifdef MOTOR602_UART_PARITY_EN
        if (parityErrO) cPerr = cPerr + 1;
`endif
    end

    task automatic idle(input int n);
        uRxI = 1'b1;
        repeat (n) @(negedge clkI);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        uRxI = 1'b0;
        repeat (CPB) @(negedge clkI);
        for (int i = 0; i < 8; i++) begin
            uRxI = b[i];
            repeat (CPB) @(negedge clkI);
        end
`ifdef MOTOR602_UART_PARITY_EN
        uRxI = (^b) ^ parFlip;
        repeat (CPB) @(negedge clkI);
`endif
        uRxI = stopBit;
        repeat (CPB) @(negedge clkI);
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        outs = {rxValidO, frameErrO, m3startO, m3forceStopO, m3invRotateO,
                m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo, 1'b0};
        nCmp++;
        if (rxByteO !== 8'h00) begin nFail++; $display("FAIL reset_byte got %h want 00", rxByteO); end
        nCmp++;
        if (outs !== 10'd0) begin nFail++; $display("FAIL reset_outs got %b want 0", outs); end
    endtask

    task automatic test_start();
        int v0, c0, k0, f0, o0, others0, others1;
        v0 = cVld; c0 = cmdCnt[0]; k0 = cCoin; f0 = cFerr; o0 = cOrphan;
        others0 = cmdCnt[1] + cmdCnt[2] + cmdCnt[3] + cmdCnt[4] + cmdCnt[5];
        sendFrame(8'h53, 1'b1);
        idle(5);
        others1 = cmdCnt[1] + cmdCnt[2] + cmdCnt[3] + cmdCnt[4] + cmdCnt[5];
        nCmp++;
        if (rxByteO !== 8'h53) begin nFail++; $display("FAIL start_byte got %h want 53", rxByteO); end
        nCmp++;
        if (cVld - v0 !== 1) begin nFail++; $display("FAIL start_vld_cycles got %0d want 1", cVld - v0); end
        nCmp++;
        if (cmdCnt[0] - c0 !== 1) begin nFail++; $display("FAIL start_pulse_cycles got %0d want 1", cmdCnt[0] - c0); end
        nCmp++;
        if (cCoin - k0 !== 1) begin nFail++; $display("FAIL start_aligned got %0d want 1", cCoin - k0); end
        nCmp++;
        if (others1 - others0 !== 0) begin nFail++; $display("FAIL start_other_cmds got %0d want 0", others1 - others0); end
        nCmp++;
        if (cFerr - f0 !== 0 || cOrphan - o0 !== 0 || m3invRotateO !== 1'b0) begin
            nFail++; $display("FAIL start_side got ferr=%0d orphan=%0d inv=%b want 0 0 0", cFerr - f0, cOrphan - o0, m3invRotateO);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic expInv [3];
        expInv = '{1'b1, 1'b0, 1'b1};
        v0 = cVld;
        for (int i = 0; i < 3; i++) begin
            sendFrame(8'h52, 1'b1);
            nCmp++;
            if (m3invRotateO !== expInv[i]) begin
                nFail++; $display("FAIL b2b_inv_%0d got %b want %b", i, m3invRotateO, expInv[i]);
            end
        end
        idle(5);
        nCmp++;
        if (cVld - v0 !== 3) begin nFail++; $display("FAIL b2b_vld got %0d want 3", cVld - v0); end
    endtask

    task automatic test_glitch();
        int v0, s0;
        v0 = cVld; s0 = cmdCnt[2];
        uRxI = 1'b0;
        repeat (3) @(negedge clkI);
        idle(30);
        nCmp++;
        if (cVld - v0 !== 0) begin nFail++; $display("FAIL glitch_vld got %0d want 0", cVld - v0); end
        sendFrame(8'h2B, 1'b1);
        idle(5);
        nCmp++;
        if (cmdCnt[2] - s0 !== 1) begin nFail++; $display("FAIL glitch_spdinc got %0d want 1", cmdCnt[2] - s0); end
        nCmp++;
        if (rxByteO !== 8'h2B) begin nFail++; $display("FAIL glitch_byte got %h want 2b", rxByteO); end
    endtask

    task automatic test_frame_error();
        int v0, f0, d0, i0;
        v0 = cVld; f0 = cFerr; d0 = cmdCnt[5]; i0 = cmdCnt[4];
        sendFrame(8'h70, 1'b0);
        uRxI = 1'b0;
        repeat (50) @(negedge clkI);
        nCmp++;
        if (cFerr - f0 !== 1) begin nFail++; $display("FAIL ferr_pulse got %0d want 1", cFerr - f0); end
        nCmp++;
        if (cVld - v0 !== 0 || cmdCnt[5] - d0 !== 0) begin
            nFail++; $display("FAIL ferr_discard got vld=%0d pwrdec=%0d want 0 0", cVld - v0, cmdCnt[5] - d0);
        end
        idle(30);
        sendFrame(8'h50, 1'b1);
        idle(5);
        nCmp++;
        if (rxByteO !== 8'h50) begin nFail++; $display("FAIL ferr_next_byte got %h want 50", rxByteO); end
        nCmp++;
        if (cmdCnt[4] - i0 !== 1) begin nFail++; $display("FAIL ferr_next_pwrinc got %0d want 1", cmdCnt[4] - i0); end
        nCmp++;
        if (cFerr - f0 !== 1 || cVld - v0 !== 1) begin
            nFail++; $display("FAIL ferr_totals got ferr=%0d vld=%0d want 1 1", cFerr - f0, cVld - v0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, x0, d0;
        logic [8:0] outs;
        logic [7:0] b;
        b = 8'h58;
        v0 = cVld; x0 = cmdCnt[1]; d0 = cmdCnt[3];
        uRxI = 1'b0;
        repeat (CPB) @(negedge clkI);
        for (int i = 0; i < 4; i++) begin
            uRxI = b[i];
            repeat (CPB) @(negedge clkI);
        end
        uRxI = b[4];
        repeat (3) @(negedge clkI);
        rstI = 1'b1;
        #1;
        outs = {rxValidO, frameErrO, m3startO, m3forceStopO, m3invRotateO,
                m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo};
        nCmp++;
        if (outs !== 9'd0 || rxByteO !== 8'h00) begin
            nFail++; $display("FAIL midrst_outs got %b byte %h want 0 00", outs, rxByteO);
        end
        repeat (2) @(negedge clkI);
        rstI = 1'b0;
        repeat (5) @(negedge clkI);
        for (int i = 5; i < 8; i++) begin
            uRxI = b[i];
            repeat (CPB) @(negedge clkI);
        end
        idle(CPB + 40);
        nCmp++;
        if (cmdCnt[1] - x0 !== 0 || cVld - v0 !== 0) begin
            nFail++; $display("FAIL midrst_ghost got stop=%0d vld=%0d want 0 0", cmdCnt[1] - x0, cVld - v0);
        end
        sendFrame(8'h2D, 1'b1);
        idle(5);
        nCmp++;
        if (cmdCnt[3] - d0 !== 1) begin nFail++; $display("FAIL midrst_spddec got %0d want 1", cmdCnt[3] - d0); end
        nCmp++;
        if (rxByteO !== 8'h2D || m3invRotateO !== 1'b0) begin
            nFail++; $display("FAIL midrst_after got byte=%h inv=%b want 2d 0", rxByteO, m3invRotateO);
        end
    endtask

    task automatic test_commands();
        logic [7:0] bytes [6];
        int         expIdx [6];
        int         c0 [6];
        int         v0, o0;
        bytes  = '{8'h58, 8'h2B, 8'h2D, 8'h50, 8'h70, 8'h73};
        expIdx = '{1, 2, 3, 4, 5, -1};
        for (int t = 0; t < 6; t++) begin
            c0 = cmdCnt; v0 = cVld; o0 = cOrphan;
            sendFrame(bytes[t], 1'b1);
            idle(5);
            nCmp++;
            if (rxByteO !== bytes[t] || cVld - v0 !== 1) begin
                nFail++; $display("FAIL cmd_%h_rx got byte=%h vld=%0d want %h 1", bytes[t], rxByteO, cVld - v0, bytes[t]);
            end
            for (int k = 0; k < 6; k++) begin
                nCmp++;
                if (cmdCnt[k] - c0[k] !== ((k == expIdx[t]) ? 1 : 0)) begin
                    nFail++; $display("FAIL cmd_%h_out%0d got %0d want %0d", bytes[t], k, cmdCnt[k] - c0[k], (k == expIdx[t]) ? 1 : 0);
                end
            end
            nCmp++;
            if (cOrphan - o0 !== 0) begin nFail++; $display("FAIL cmd_%h_align got %0d want 0", bytes[t], cOrphan - o0); end
        end
    endtask

`ifdef MOTOR602_UART_PARITY_EN
    task automatic test_parity();
        int v0, s0, p0;
        v0 = cVld; s0 = cmdCnt[0]; p0 = cPerr;
        parFlip = 1'b1;
        sendFrame(8'h53, 1'b1);
        idle(5);
        nCmp++;
        if (cPerr - p0 !== 1) begin nFail++; $display("FAIL par_err got %0d want 1", cPerr - p0); end
        nCmp++;
        if (cVld - v0 !== 0 || cmdCnt[0] - s0 !== 0) begin
            nFail++; $display("FAIL par_discard got vld=%0d start=%0d want 0 0", cVld - v0, cmdCnt[0] - s0);
        end
        parFlip = 1'b0;
        sendFrame(8'h53, 1'b1);
        idle(5);
        nCmp++;
        if (cmdCnt[0] - s0 !== 1 || cPerr - p0 !== 1) begin
            nFail++; $display("FAIL par_good got start=%0d perr=%0d want 1 1", cmdCnt[0] - s0, cPerr - p0);
        end
    endtask
`endif

    initial begin
        rstI = 1'b1;
        uRxI = 1'b1;
        repeat (3) @(negedge clkI);
        test_reset();
        rstI = 1'b0;
        idle(40);
        test_start();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_commands();
`ifdef MOTOR602_UART_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/motor602_uart_cmd_rx.md
Name: motor602_uart_cmd_rx

Overview:
- Serial command receiver for the 3-phase motor controller; the receive end of the board UART link whose transmit pin is currently tied low.
- Deserialises 8N1 frames from the host into bytes and decodes single-character commands.
- Emits one-cycle control pulses equivalent to the motor push-button inputs (start, force-stop, invert, speed/power inc/dec), so a host can drive the controller without buttons.

Parameters:
- CLK_HZ, 50000000, frequency of clkI in Hz.
- BAUD, 115200, line bit rate.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer truncation; 434 at defaults), clocks per bit; must be >= 4.

Ports:
- clkI  input  1  single system clock; all logic on rising edge.
- rstI  input  1  asynchronous, active-high reset.
- uRxI  input  1  asynchronous UART line; idle high.
- rxByteO  output  8  last correctly received byte; held until the next good byte.
- rxValidO  output  1  one-cycle pulse when rxByteO updates.
- frameErrO  output  1  one-cycle pulse when the stop bit is sampled low.
- m3startO  output  1  pulse on 'S' (0x53).
- m3forceStopO  output  1  pulse on 'X' (0x58).
- m3invRotateO  output  1  level; toggles on 'R' (0x52).
- m3speedINCo  output  1  pulse on '+' (0x2B).
- m3speedDECo  output  1  pulse on '-' (0x2D).
- m3powerINCo  output  1  pulse on 'P' (0x50).
- m3powerDECo  output  1  pulse on 'p' (0x70).

Behaviour:
- Reset: all outputs 0; rxByteO = 0x00; FSM in IDLE; synchroniser flops preset to 1.
- uRxI passes through a 2-flop synchroniser; all decisions use the synchronised value (rxS).
- FSM states and transitions:
  - IDLE: on rxS falling (1 -> 0), go to START; clear the bit counter.
  - START: at count CLKS_PER_BIT/2, sample rxS. If 1, treat as a glitch and return to IDLE with no output. If 0, go to DATA and reset the counter.
  - DATA: every CLKS_PER_BIT clocks, sample one bit, LSB first, into a shift register. After 8 bits, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample. If 1, load rxByteO, pulse rxValidO, and return to IDLE. If 0, pulse frameErrO, discard the byte, and go to BREAK.
  - BREAK: wait until rxS = 1 for one full CLKS_PER_BIT, then return to IDLE. A continuous low line never produces further frames.
- Latency:
  - rxValidO asserts in the cycle after the stop-bit sample clock edge.
  - The command pulse asserts in the same cycle as rxValidO.
  - m3invRotateO toggles on that same edge.
- Command pulses are exactly one clkI wide. Unknown bytes raise rxValidO only.
- Case matters: 'P' and 'p' are distinct; 's' is unrecognised.
- Back-to-back frames (stop bit directly followed by a start bit) must be received without loss: IDLE detects the falling edge on the first cycle after returning.
- rstI asserted mid-frame: immediate return to reset values. After release, a partially received frame is ignored until the line is seen idle-high and then falls.
- Sampling tolerates ±2% baud mismatch at defaults; no oversampling majority vote.

Optional Feature:
- Macro: MOTOR602_UART_PARITY_EN.
- Defined:
  - Frame becomes 8E1; a PARITY state follows DATA and samples one extra bit.
  - Even-parity mismatch adds a port parityErrO (output, 1), pulsed at the stop-bit sample.
  - On parity error, the byte is discarded: no rxValidO, no command pulse.
  - A frame error takes precedence over a parity error (only frameErrO pulses).
- Undefined: 8N1 only; no PARITY state and no parityErrO port.

Decomposition:
- Shared include (motor602 def include):
  - command byte constants CMD_START, CMD_STOP, CMD_INV, CMD_SPD_INC, CMD_SPD_DEC, CMD_PWR_INC, CMD_PWR_DEC;
  - FSM state encodings;
  - default CLK_HZ and BAUD.
- One sub-module, motor602_uart_rx_core: synchroniser, FSM, rxByteO, rxValidO, frameErrO (and parity).
- Top level = core plus a registered command decoder and the invert toggle flop.

Test Plan:
- Run with CLK_HZ=1000000, BAUD=100000 (CLKS_PER_BIT=10).
  1. Send 0x53 (8N1) -> rxByteO=0x53, one rxValidO and one m3startO pulse, both 1 cycle wide; all other command outputs stay 0.
  2. Send 'R','R','R' back-to-back with no idle gap -> three rxValidO pulses; m3invRotateO goes 0->1->0->1.
  3. Drive uRxI low for 3 clocks, then high -> no rxValidO, FSM back in IDLE; a following 0x2B still produces m3speedINCo.
  4. Send 0x70 with the stop bit forced low, hold the line low 50 clocks, then send 0x50 -> one frameErrO pulse, no m3powerDECo; then rxByteO=0x50 and one m3powerINCo pulse.
  5. Assert rstI during data bit 4 of 0x58, release it, then send 0x2D -> no m3forceStopO; all outputs 0 during reset; one m3speedDECo pulse follows.
  6. With MOTOR602_UART_PARITY_EN, send 0x53 with parity bit 1 (wrong) -> parityErrO pulse, no rxValidO; with parity bit 0 -> m3startO pulse.
